// File: rtl/seq_mul16_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Holds the FSM state enum, default width and counter-width helper.
package seq_mul16_pkg;

  localparam int W_DEF   = 16;
  localparam int SLICE_W = 4;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_w(W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mul16_add.sv
// mul_add2w: N-bit combinational adder from 4-bit carry-select slices.
// Ports: a_i, b_i (addends), s_o (sum), cout_o (carry out). N % 4 == 0.
module mul_add2w
  import seq_mul16_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] s_o,
  output logic         cout_o
);

  localparam int NS = N / SLICE_W;

  logic [NS:0] c;

  assign c[0] = 1'b0;

  for (genvar g = 0; g < NS; g++) begin : g_slice
    logic [SLICE_W:0] s0;
    logic [SLICE_W:0] s1;

    // Both carry-in outcomes precomputed; the ripple only drives muxes.
    assign s0 = {1'b0, a_i[SLICE_W*g +: SLICE_W]}
              + {1'b0, b_i[SLICE_W*g +: SLICE_W]};
    assign s1 = s0 + (SLICE_W+1)'(1);

    assign s_o[SLICE_W*g +: SLICE_W] =
      c[g] ? s1[SLICE_W-1:0] : s0[SLICE_W-1:0];
    assign c[g+1] = c[g] ? s1[SLICE_W] : s0[SLICE_W];
  end

  assign cout_o = c[NS];

endmodule

// File: rtl/seq_mul16.sv
// seq_mul16: W-bit unsigned sequential shift-add multiplier, 2W product.
// Ports: clk, rst (sync, active-high), start, a, b -> busy, done, product.
// Option: SEQ_MUL16_EARLY_EXIT_EN ends RUN once the multiplier is spent.
module seq_mul16
  import seq_mul16_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W-1);

  state_e          state_q;
  logic [2*W-1:0]  mcand_q;
  logic [2*W-1:0]  acc_q;
  logic [2*W-1:0]  acc_d;
  logic [2*W-1:0]  sum;
  logic [W-1:0]    mplier_q;
  logic [W-1:0]    mplier_d;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [2*W-1:0]  prod_q;
  logic            last_iter;
  logic            add_cout_unused;

  mul_add2w #(
    .N (2*W)
  ) u_add (
    .a_i    (acc_q),
    .b_i    (mcand_q),
    .s_o    (sum),
    .cout_o (add_cout_unused)
  );

  always_comb begin
    acc_d     = mplier_q[0] ? sum : acc_q;
    mplier_d  = mplier_q >> 1;
    last_iter = (cnt_q == LAST);
`ifdef SEQ_MUL16_EARLY_EXIT_EN
    // No set bits left: remaining iterations would add nothing.
    last_iter = last_iter | (mplier_d == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= {{W{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_iter) begin
            // Take the sum of this final iteration, not the stale acc.
            prod_q  <= acc_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_seq_mul16.sv
// Self-checking bench for seq_mul16: vector table plus corner sequences.
// Expected products go into a queue and are matched on each done pulse.
module tb_seq_mul16;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  always #5 clk = ~clk;

  seq_mul16 #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  typedef struct {
    string         name;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2*W-1:0] p;
  } vec_t;

  int             n_run  = 0;
  int             n_fail = 0;
  logic [2*W-1:0] sb[$];
  string          cur = "none";

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [W-1:0] bv);
    int l;
    l = W + 1;
`ifdef SEQ_MUL16_EARLY_EXIT_EN
    l = 2;
    for (int i = 0; i < W; i++)
      if (bv[i]) l = i + 2;
`endif
    return l;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending request.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL %s_spurious_done: got done=1 expected done=0",
                 cur);
      end else begin
        logic [2*W-1:0] e;
        e = sb.pop_front();
        chk({cur, "_product"}, 64'(product), 64'(e));
      end
    end
  end

  task automatic start_op(input logic [W-1:0] av,
                          input logic [W-1:0] bv,
                          input logic [2*W-1:0] pv);
    start = 1'b1;
    a     = av;
    b     = bv;
    sb.push_back(pv);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  // n0 = edges since the sampling edge already elapsed (sampling edge = 1).
  task automatic wait_done(input int lat, input int n0, input bit tail);
    int n;
    int bc;
    bit seen;
    n    = n0;
    bc   = 0;
    seen = 1'b0;
    while (1) begin
      if (busy) bc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (n >= lat + 4) break;
      @(posedge clk);
      #1;
      n++;
    end
    if (!seen) begin
      n_run++;
      n_fail++;
      $display("FAIL %s_timeout: got no done after %0d edges expected %0d",
               cur, n, lat);
    end else begin
      chk({cur, "_latency"}, 64'(n), 64'(lat));
      chk({cur, "_busy_cycles"}, 64'(bc), 64'(lat - n0 + 1));
      if (tail) begin
        @(posedge clk);
        #1;
        chk({cur, "_done_pulse"}, 64'(done), 64'(0));
        chk({cur, "_busy_idle"}, 64'(busy), 64'(0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    logic [2*W-1:0] last_p;

    vt[0] = '{"3x5",     16'h0003, 16'h0005, 32'h0000_000F};
    vt[1] = '{"ffffx2",  16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vt[2] = '{"zero_a",  16'h0000, 16'h1234, 32'h0000_0000};
    vt[3] = '{"zero_b",  16'hBEEF, 16'h0000, 32'h0000_0000};
    vt[4] = '{"1x8000",  16'h0001, 16'h8000, 32'h0000_8000};
    vt[5] = '{"ffx ff",  16'h00FF, 16'h00FF, 32'h0000_FE01};
    vt[6] = '{"7x1",     16'h0007, 16'h0001, 32'h0000_0007};
    vt[7] = '{"7x8000",  16'h0007, 16'h8000, 32'h0003_8000};
    vt[8] = '{"8000sq",  16'h8000, 16'h8000, 32'h4000_0000};

    rst   = 1'b1;
    start = 1'b1;
    a     = 16'h1111;
    b     = 16'h2222;
    repeat (3) @(posedge clk);
    #1;
    cur = "reset";
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_product", 64'(product), 64'(0));
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk);
    #1;

    last_p = '0;
    for (int i = 0; i < 9; i++) begin
      cur = vt[i].name;
      start_op(vt[i].a, vt[i].b, vt[i].p);
      wait_done(lat_of(vt[i].b), 1, 1'b1);
      last_p = vt[i].p;
    end

    // Start pulsed mid-RUN must be ignored; product holds meanwhile.
    cur = "ignore";
    start_op(16'h1234, 16'h0010, 32'h0001_2340);
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'h0001;
    b     = 16'h0001;
    chk("ignore_product_hold", 64'(product), 64'(last_p));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ignore_busy", 64'(busy), 64'(1));
    wait_done(lat_of(16'h0010), 3, 1'b1);
    repeat (20) @(posedge clk);
    #1;

    // Reset mid-RUN aborts without a done pulse.
    cur = "abort";
    start_op(16'h00FF, 16'h00FF, 32'h0000_FE01);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_product", 64'(product), 64'(0));
    repeat (20) @(posedge clk);
    #1;
    cur = "after_abort";
    start_op(16'h0002, 16'h0003, 32'h0000_0006);
    wait_done(lat_of(16'h0003), 1, 1'b1);

    // Back-to-back: start held from the done cycle into the next IDLE.
    cur = "b2b_first";
    start_op(16'h0002, 16'h0003, 32'h0000_0006);
    wait_done(lat_of(16'h0003), 1, 1'b0);
    start = 1'b1;
    a     = 16'h0004;
    b     = 16'h0005;
    @(posedge clk);
    #1;
    chk("b2b_idle_busy", 64'(busy), 64'(0));
    chk("b2b_idle_done", 64'(done), 64'(0));
    sb.push_back(32'h0000_0014);
    cur = "b2b_second";
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    wait_done(lat_of(16'h0005), 1, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
